// File: rtl/ex_mem_stage_pkg.sv
// Shared constants for the EX/MEM stage: ALU compare codes, branch classes,
// writeback selects and the default reset PC.
package ex_mem_stage_pkg;

    typedef enum logic [1:0] {
        EQUAL   = 2'b00,
        GREATER = 2'b01,
        LESS    = 2'b10,
        OTHER   = 2'b11
    } cmp_e;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLT  = 3'd3,
        BR_BGE  = 3'd4,
        BR_JAL  = 3'd5,
        BR_JALR = 3'd6
    } br_type_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ex_mem_stage_branch_resolve.sv
// Combinational branch resolution: taken decision from the ALU compare code
// and the redirect target mux.
module ex_mem_stage_branch_resolve
    import ex_mem_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      br_type,
    input  logic [1:0]      zero,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] alu_result,
    output logic            taken,
    output logic [XLEN-1:0] target
);

    br_type_e br;
    cmp_e     cmp;

    assign br  = br_type_e'(br_type);
    assign cmp = cmp_e'(zero);

    always_comb begin
        taken = 1'b0;
        unique case (br)
            BR_BEQ:          taken = (cmp == EQUAL);
            BR_BNE:          taken = (cmp != EQUAL);
            BR_BLT:          taken = (cmp == LESS);
            BR_BGE:          taken = (cmp == EQUAL) || (cmp == GREATER);
            BR_JAL, BR_JALR: taken = 1'b1;
            default:         taken = 1'b0;
        endcase
    end

    // JALR target comes from the ALU (rs1+imm) with the low bit forced clear.
    assign target = (br == BR_JALR) ? {alu_result[XLEN-1:1], 1'b0} : ex_pc + ex_imm;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch redirect, wrong-path kill, stall and
// flush handling.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = ex_mem_stage_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] alu_result,
    input  logic [1:0]      zero,
    input  logic [2:0]      ex_br_type,
    input  logic [XLEN-1:0] ex_rs2_data,
    input  logic [4:0]      ex_rd,
    input  logic            ex_reg_we,
    input  logic            ex_mem_we,
    input  logic [1:0]      ex_wb_sel,
    output logic            mem_valid,
    output logic [XLEN-1:0] mem_alu_result,
    output logic [XLEN-1:0] mem_pc4,
    output logic [XLEN-1:0] mem_rs2_data,
    output logic [4:0]      mem_rd,
    output logic            mem_reg_we,
    output logic            mem_mem_we,
    output logic [1:0]      mem_wb_sel,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    logic            kill;
    logic            accept;
    logic            taken;
    logic            redirect;
    logic [XLEN-1:0] target;

    ex_mem_stage_branch_resolve #(
        .XLEN(XLEN)
    ) u_branch_resolve (
        .br_type    (ex_br_type),
        .zero       (zero),
        .ex_pc      (ex_pc),
        .ex_imm     (ex_imm),
        .alu_result (alu_result),
        .taken      (taken),
        .target     (target)
    );

    assign accept   = ex_valid & ~kill;
    assign redirect = accept & taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid      <= 1'b0;
            mem_alu_result <= '0;
            mem_pc4        <= '0;
            mem_rs2_data   <= '0;
            mem_rd         <= '0;
            mem_reg_we     <= 1'b0;
            mem_mem_we     <= 1'b0;
            mem_wb_sel     <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= RESET_PC;
            kill           <= 1'b0;
        end else begin
            if (!stall) begin
                mem_alu_result <= alu_result;
                mem_pc4        <= ex_pc + XLEN'(4);
                mem_rs2_data   <= ex_rs2_data;
                mem_rd         <= ex_rd;
                mem_wb_sel     <= ex_wb_sel;
            end
            // Flush wins over both stall and a taken branch; redirect_pc is left alone.
            if (flush) begin
                mem_valid      <= 1'b0;
                mem_reg_we     <= 1'b0;
                mem_mem_we     <= 1'b0;
                redirect_valid <= 1'b0;
                kill           <= 1'b0;
            end else if (!stall) begin
                mem_valid      <= accept;
                mem_reg_we     <= accept & ex_reg_we;
                mem_mem_we     <= accept & ex_mem_we;
                redirect_valid <= redirect;
                kill           <= redirect;
                if (redirect) begin
                    redirect_pc <= target;
                end
            end
        end
    end

endmodule
